// File: rtl/sd_dat_read_seq.sv
// sd_dat_read_seq
// Sequences one single-lane (DAT0) SD read data block. All sampling and state
// advance happen only on cycles where sd_clk_en_i is high ("ticks").
// Flow: wait for start bit -> deserialise block_len_i bytes MSB-first
// (driving the external CRC16 unit's shift enable) -> receive 16 CRC bits and
// compare against the latched CRC16 value -> sample end bit -> report status.
//
// Ports:
//   clk_i, rst_i      system clock, asynchronous active-high reset
//   sd_clk_en_i       SD bit-time strobe
//   start_i           one-cycle pulse, arms a read (only in IDLE/DONE)
//   abort_i           cancels any operation (priority over start_i)
//   block_len_i       bytes per block, sampled at start_i (0 means 1)
//   timeout_i         max ticks to wait for start bit, sampled at start_i
//   dat_ser_i         DAT0 line
//   crc16_i           current value of the external CRC16 register
//   crc_shift_o       CRC16 shift enable (low clears the unit on a tick)
//   data_o            deserialised byte
//   data_valid_o      one-cycle pulse, data_o valid
//   busy_o            high from accepted start_i until DONE
//   done_o            one-cycle pulse on entering DONE
//   crc_err_o, end_err_o, timeout_o   status flags, held until next start
//
// Handshake: start_i is a request-only pulse (no ready); it is accepted when
// state is IDLE or DONE and abort_i is low, dropped otherwise. data_valid_o
// and done_o are single-cycle strobes with no back-pressure; the sink must
// take data_o on the cycle data_valid_o is high.
module sd_dat_read_seq #(
  parameter int LEN_W = 12,
  parameter int TO_W  = 24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sd_clk_en_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [LEN_W-1:0] block_len_i,
  input  logic [TO_W-1:0]  timeout_i,
  input  logic             dat_ser_i,
  input  logic [15:0]      crc16_i,
  output logic             crc_shift_o,
  output logic [7:0]       data_o,
  output logic             data_valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             crc_err_o,
  output logic             end_err_o,
  output logic             timeout_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_START, S_DATA, S_CRC, S_END, S_DONE
  } state_t;

  localparam logic [LEN_W+2:0] BIT_ONE = 1;
  localparam logic [LEN_W-1:0] LEN_ONE = 1;
  localparam logic [TO_W-1:0]  TO_ONE  = 1;

  // State register is a named signal so checkers can bind to it directly.
  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [TO_W-1:0]  to_lim_q;
  logic [TO_W-1:0]  to_cnt_q;
  logic [LEN_W+2:0] bit_cnt_q;
  logic [7:0]       byte_sr_q;
  logic [3:0]       crc_cnt_q;
  logic [15:0]      exp_crc_q;
  logic [15:0]      rx_crc_q;

  logic             tick;
  logic [LEN_W+2:0] last_bit;
  logic [7:0]       byte_next;
  logic [TO_W-1:0]  to_cnt_next;
  logic             to_hit;

  assign tick        = sd_clk_en_i;
  assign last_bit    = {len_q, 3'b000} - BIT_ONE;
  assign byte_next   = {byte_sr_q[6:0], dat_ser_i};
  assign to_cnt_next = to_cnt_q + TO_ONE;
  // A zero limit times out on the very first idle tick.
  assign to_hit      = (to_lim_q == '0) || (to_cnt_next == to_lim_q);

  // The CRC unit must shift on every DATA tick, so this is a direct decode of
  // the state register rather than a registered copy.
  assign crc_shift_o = (state == S_DATA);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      len_q        <= '0;
      to_lim_q     <= '0;
      to_cnt_q     <= '0;
      bit_cnt_q    <= '0;
      byte_sr_q    <= '0;
      crc_cnt_q    <= '0;
      exp_crc_q    <= '0;
      rx_crc_q     <= '0;
      data_o       <= '0;
      data_valid_o <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      crc_err_o    <= 1'b0;
      end_err_o    <= 1'b0;
      timeout_o    <= 1'b0;
    end else begin
      // Strobes default low so they never repeat on non-tick cycles.
      data_valid_o <= 1'b0;
      done_o       <= 1'b0;
      if (abort_i) begin
        state     <= S_IDLE;
        busy_o    <= 1'b0;
        crc_err_o <= 1'b0;
        end_err_o <= 1'b0;
        timeout_o <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start_i) begin
              state     <= S_WAIT_START;
              busy_o    <= 1'b1;
              crc_err_o <= 1'b0;
              end_err_o <= 1'b0;
              timeout_o <= 1'b0;
              len_q     <= (block_len_i == '0) ? LEN_ONE : block_len_i;
              to_lim_q  <= timeout_i;
              to_cnt_q  <= '0;
              bit_cnt_q <= '0;
              crc_cnt_q <= '0;
              byte_sr_q <= '0;
              rx_crc_q  <= '0;
            end
          end
          S_WAIT_START: begin
            if (tick) begin
              if (!dat_ser_i) begin
                state     <= S_DATA;
                bit_cnt_q <= '0;
              end else if (to_hit) begin
                // Counter parks at the compare point.
                to_cnt_q  <= to_lim_q;
                timeout_o <= 1'b1;
                state     <= S_DONE;
                done_o    <= 1'b1;
                busy_o    <= 1'b0;
              end else begin
                to_cnt_q <= to_cnt_next;
              end
            end
          end
          S_DATA: begin
            if (tick) begin
              byte_sr_q <= byte_next;
              bit_cnt_q <= bit_cnt_q + BIT_ONE;
              if (bit_cnt_q[2:0] == 3'd7) begin
                data_o       <= byte_next;
                data_valid_o <= 1'b1;
              end
              if (bit_cnt_q == last_bit) begin
                state     <= S_CRC;
                crc_cnt_q <= '0;
              end
            end
          end
          S_CRC: begin
            if (tick) begin
              // crc16_i still holds the final value on the first CRC tick;
              // the unit clears on this same edge because shift is low.
              if (crc_cnt_q == 4'd0) exp_crc_q <= crc16_i;
              rx_crc_q  <= {rx_crc_q[14:0], dat_ser_i};
              crc_cnt_q <= crc_cnt_q + 4'd1;
              if (crc_cnt_q == 4'd15) state <= S_END;
            end
          end
          S_END: begin
            if (tick) begin
              end_err_o <= ~dat_ser_i;
              crc_err_o <= (rx_crc_q != exp_crc_q);
              state     <= S_DONE;
              done_o    <= 1'b1;
              busy_o    <= 1'b0;
            end
          end
          default: begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/sd_dat_read_seq.md
Name: sd_dat_read_seq

Overview:
- Sequences one single-lane (DAT0) SD read data block, gated by the SD clock-enable strobe.
- Detects the start bit, deserialises `block_len_i` bytes MSB-first and drives the shift control of the external CRC16 unit.
- Captures the computed CRC, receives and compares the transmitted CRC, checks the end bit, then reports status.
- Sits between the SD data-path top level and the DMA/FIFO byte sink. The CRC16 unit's serial input is wired to the same DAT0 line at top level.

Parameters:
- LEN_W, 12, width of block length in bytes (max block 2^LEN_W-1).
- TO_W, 24, width of start-bit timeout counter.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-high reset.
- sd_clk_en_i  in  1  SD bit-time strobe; all sampling and state advance occur only on cycles where it is high ("tick").
- start_i  in  1  one-cycle pulse; arms a block read (ignored unless IDLE or DONE).
- abort_i  in  1  cancels any operation.
- block_len_i  in  LEN_W  bytes per block; sampled at start_i; 0 treated as 1.
- timeout_i  in  TO_W  max ticks to wait for start bit; sampled at start_i.
- dat_ser_i  in  1  DAT0 line.
- crc16_i  in  16  current value of external CRC16 register.
- crc_shift_o  out  1  shift enable to CRC16 unit (low clears it on a tick).
- data_o  out  8  deserialised byte.
- data_valid_o  out  1  one-cycle pulse, data_o valid.
- busy_o  out  1  high from start_i accepted until DONE.
- done_o  out  1  one-cycle pulse on entering DONE.
- crc_err_o  out  1  status: received CRC != computed CRC.
- end_err_o  out  1  status: end bit sampled 0.
- timeout_o  out  1  status: no start bit within timeout_i ticks.

Behaviour:
- Reset values: state IDLE. All outputs 0, all counters and shift registers 0. Asynchronous assertion; deassertion takes effect on the next edge.
- States: IDLE, WAIT_START, DATA, CRC, END, DONE.
- IDLE/DONE:
  - start_i moves to WAIT_START on the next edge.
  - start_i clears the status flags, loads block_len_i and timeout_i, and zeroes counters.
  - busy_o = 1 in every state except IDLE/DONE.
- WAIT_START, on each tick:
  - dat_ser_i == 0 moves to DATA; the bit counter resets.
  - Otherwise the timeout counter increments. When it equals timeout_i (after the increment), set timeout_o and go to DONE.
  - timeout_i == 0 times out on the first tick without a start bit.
- DATA:
  - crc_shift_o = 1 combinationally while state == DATA, including the non-tick cycles.
  - Each tick shifts dat_ser_i into the byte register LSB-side (first bit received = bit 7).
  - After the 8th tick of a byte: data_o is updated and data_valid_o pulses for exactly one clk cycle on the following cycle. The pulse is never repeated on non-tick cycles.
  - On the tick of bit 8*len-1, go to CRC.
- CRC:
  - crc_shift_o = 0.
  - On the first CRC tick, latch crc16_i as expected CRC. It still holds the final value; the CRC unit clears on this same tick.
  - 16 ticks shift dat_ser_i MSB-first into the received-CRC register. After the 16th tick, go to END.
- END:
  - On one tick, sample dat_ser_i. If 0, set end_err_o.
  - Set crc_err_o if received != expected.
  - Go to DONE; done_o pulses one cycle on entry. Status flags are held until the next accepted start_i.
- abort_i:
  - Any state goes to IDLE on the next edge, with no done_o and no further data_valid_o. A byte pending validation is dropped.
  - Status flags are cleared. crc_shift_o = 0, so the CRC unit clears on the next tick.
  - abort_i has priority over start_i in the same cycle.
- start_i while busy is ignored. sd_clk_en_i held low freezes all states and counters.
- Counters:
  - Bit counter is LEN_W+3 bits wide and never wraps within a legal block.
  - Timeout counter saturates at the compare point.

Test Plan:
- 512 bytes of 0xFF, start bit after 3 idle ticks, CRC bits 0x7FA1, end bit 1 -> 512 data_valid_o pulses of 0xFF, then done_o, crc_err_o=0, end_err_o=0, timeout_o=0.
- block_len_i=1, byte 0x00, CRC 0x0000, end bit 1 -> one pulse data_o=0x00, done_o, no errors.
- Same as the 0x00 case but CRC 0x0001 -> crc_err_o=1. Separately, end bit 0 -> end_err_o=1 and crc_err_o=0.
- timeout_i=5, DAT0 held 1 -> done_o on the 5th tick, timeout_o=1, no data_valid_o.
- abort_i mid-DATA (byte 3 of 512) -> IDLE next cycle, busy_o=0, no done_o. A subsequent start_i with a 1-byte block 0x00, CRC 0x0000, end bit 1 completes with no errors, proving the CRC unit cleared.
- sd_clk_en_i asserted 1 in 4 cycles with byte 0xA5 -> data_o=0xA5, exactly one data_valid_o pulse; rst_i asserted mid-CRC -> all outputs 0 immediately.
